// File: rtl/boot_loader_if.sv
// Byte-stream receive channel and memory write port of the boot loader.
// The slave modport is the loader's view; the master modport is the host/memory side.
interface boot_loader_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        rx_data_i;
    logic              rx_valid_i;
    logic              rx_ready_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_data_o;
    logic              mem_we_o;

    modport slave (
        input  rx_data_i, rx_valid_i,
        output rx_ready_o, mem_addr_o, mem_data_o, mem_we_o
    );

    modport master (
        output rx_data_i, rx_valid_i,
        input  rx_ready_o, mem_addr_o, mem_data_o, mem_we_o
    );
endinterface

// File: rtl/boot_loader.sv
// Framed byte-stream program loader: writes the payload to memory and holds the CPU in reset
// until a whole frame is stored. Define BOOT_CHECKSUM_EN to add the trailing checksum byte and ERR state.
module boot_loader #(
    parameter int         ADDR_W    = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    boot_loader_if.slave  bus,
    output logic          cpu_rst_o,
    output logic          done_o,
    output logic          err_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN_H,
        S_LEN_L,
        S_DATA,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM,
        S_ERR,
`endif
        S_DONE
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam state_t POST_DATA = S_CSUM;
`else
    localparam state_t POST_DATA = S_DONE;
`endif

    state_t            state_q, state_d;
    logic              accept;
    logic              len_zero;
    logic              last_byte;
    logic [7:0]        addr_hi_q;
    logic [7:0]        len_hi_q;
    logic [15:0]       len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_data_q;
    logic              mem_we_q;
    logic              cpu_rst_q;
    logic              done_q;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum_q;
    logic              err_q;
`endif

    assign accept    = bus.rx_valid_i && bus.rx_ready_o;
    assign len_zero  = ({len_hi_q, bus.rx_data_i} == 16'd0);
    assign last_byte = (len_q == 16'd1);

    // Ready decodes only the registered state, so it never depends on rx_valid_i.
    assign bus.rx_ready_o = (state_q != S_DONE);
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.mem_data_o = mem_data_q;
    assign bus.mem_we_o   = mem_we_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign done_o         = done_q;
`ifdef BOOT_CHECKSUM_EN
    assign err_o          = err_q;
`else
    assign err_o          = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept && bus.rx_data_i == SYNC_BYTE) state_d = S_ADDR_H;
            S_ADDR_H: if (accept) state_d = S_ADDR_L;
            S_ADDR_L: if (accept) state_d = S_LEN_H;
            S_LEN_H:  if (accept) state_d = S_LEN_L;
            S_LEN_L:  if (accept) state_d = len_zero ? POST_DATA : S_DATA;
            S_DATA:   if (accept && last_byte) state_d = POST_DATA;
`ifdef BOOT_CHECKSUM_EN
            S_CSUM:   if (accept) state_d = (bus.rx_data_i == csum_q) ? S_DONE : S_ERR;
            S_ERR:    if (accept && bus.rx_data_i == SYNC_BYTE) state_d = S_ADDR_H;
`endif
            S_DONE:   state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_hi_q  <= '0;
            len_hi_q   <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            mem_we_q  <= 1'b0;
            // CPU release trails done by one cycle so the last write has landed first.
            cpu_rst_q <= ~done_q;
            done_q    <= done_q | (state_d == S_DONE);
`ifdef BOOT_CHECKSUM_EN
            err_q     <= (state_d == S_ERR);
`endif
            if (accept) begin
                case (state_q)
                    S_ADDR_H: addr_hi_q <= bus.rx_data_i;
                    S_ADDR_L: addr_q    <= ADDR_W'({addr_hi_q, bus.rx_data_i});
                    S_LEN_H:  len_hi_q  <= bus.rx_data_i;
                    S_LEN_L:  len_q     <= {len_hi_q, bus.rx_data_i};
                    S_DATA: begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= addr_q;
                        mem_data_q <= bus.rx_data_i;
                        addr_q     <= addr_q + ADDR_W'(1);
                        len_q      <= len_q - 16'd1;
                    end
                    default: ;
                endcase
`ifdef BOOT_CHECKSUM_EN
                // Bytes seen while hunting for sync restart the sum; header and payload accumulate.
                if (state_q == S_IDLE || state_q == S_ERR) begin
                    csum_q <= '0;
                end else begin
                    csum_q <= csum_q + bus.rx_data_i;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: stimulus queues expected memory writes, a monitor pops and compares them.
module tb_boot_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_rst, done, err;

    always #5 clk = ~clk;

    boot_loader_if #(.ADDR_W(16)) bus ();

    boot_loader #(.ADDR_W(16), .SYNC_BYTE(8'hA5)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .cpu_rst_o (cpu_rst),
        .done_o    (done),
        .err_o     (err)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         wr_count = 0;
    int         w0;
    logic [7:0] mem [logic [15:0]];

    logic [7:0] pl_basic[$] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] pl_wrap[$]  = '{8'hAA, 8'hBB};
    logic [7:0] pl_zero[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && bus.mem_we_o) begin
            wr_count++;
            mem[bus.mem_addr_o] = bus.mem_data_o;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0h data %0h with nothing expected",
                         bus.mem_addr_o, bus.mem_data_o);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.mem_addr_o), 32'(e.addr));
                check("wr_data", 32'(bus.mem_data_o), 32'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        while (!bus.rx_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.rx_ready_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: rx_ready 0 expected 1 for byte %0h", b);
        end
        @(posedge clk);
        #1;
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic gap(input bit stall);
        int n;
        n = stall ? int'($urandom_range(0, 3)) : 0;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [7:0] pl[$],
                              input logic [7:0] cs, input bit stall);
        logic [15:0] len;
        len = 16'(pl.size());
        gap(stall); send_byte(8'hA5);
        gap(stall); send_byte(a[15:8]);
        gap(stall); send_byte(a[7:0]);
        gap(stall); send_byte(len[15:8]);
        gap(stall); send_byte(len[7:0]);
        foreach (pl[i]) begin
            exp_q.push_back(wr_t'{addr: a + 16'(i), data: pl[i]});
            gap(stall);
            send_byte(pl[i]);
        end
`ifdef BOOT_CHECKSUM_EN
        gap(stall); send_byte(cs);
`else
        if (cs === 8'hxx) $display("note: undefined checksum argument");
`endif
    endtask

    // Called right after the frame's final handshake edge.
    task automatic expect_done(input string tag);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_cpu_rst_held"}, 32'(cpu_rst), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_cpu_rst_released"}, 32'(cpu_rst), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_ready_in_done"}, 32'(bus.rx_ready_o), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(bus.rx_ready_o), 32'd1);
        check({tag, "_mem_we"}, 32'(bus.mem_we_o), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr_o), 32'd0);
        check({tag, "_mem_data"}, 32'(bus.mem_data_o), 32'd0);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        bus.rx_valid_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_data_i  = 8'h00;
        bus.rx_valid_i = 1'b0;
        #12;
        check_reset_values("por");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic load
        w0 = wr_count;
        send_frame(16'h0100, pl_basic, 8'h6A, 1'b0);
        expect_done("basic");
        check("basic_wr_count", 32'(wr_count - w0), 32'd3);
        check("basic_mem_0100", 32'(mem[16'h0100]), 32'h11);
        check("basic_mem_0102", 32'(mem[16'h0102]), 32'h33);

`ifdef BOOT_CHECKSUM_EN
        // Bad checksum, then retry without reset
        do_reset();
        send_frame(16'h0100, pl_basic, 8'h6B, 1'b0);
        check("bad_err", 32'(err), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bad_cpu_rst", 32'(cpu_rst), 32'd1);
        check("bad_ready", 32'(bus.rx_ready_o), 32'd1);
        send_byte(8'h00);
        check("bad_err_sticky", 32'(err), 32'd1);
        send_frame(16'h0100, pl_basic, 8'h6A, 1'b0);
        expect_done("retry");
`endif

        // Leading garbage with stalls
        do_reset();
        send_byte(8'h00);
        gap(1'b1);
        send_byte(8'hFF);
        gap(1'b1);
        send_byte(8'h5A);
        w0 = wr_count;
        send_frame(16'h0100, pl_basic, 8'h6A, 1'b1);
        expect_done("garbage");
        check("garbage_wr_count", 32'(wr_count - w0), 32'd3);
        check("garbage_mem_0101", 32'(mem[16'h0101]), 32'h22);

        // Address wrap
        do_reset();
        send_frame(16'hFFFF, pl_wrap, 8'h65, 1'b0);
        expect_done("wrap");
        check("wrap_mem_ffff", 32'(mem[16'hFFFF]), 32'hAA);
        check("wrap_mem_0000", 32'(mem[16'h0000]), 32'hBB);

        // Zero length
        do_reset();
        w0 = wr_count;
        send_frame(16'h0010, pl_zero, 8'h10, 1'b0);
        expect_done("zero");
        check("zero_wr_count", 32'(wr_count - w0), 32'd0);

        // Reset mid-payload
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h03);
        exp_q.push_back(wr_t'{addr: 16'h0100, data: 8'h11});
        send_byte(8'h11);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        w0 = wr_count;
        send_frame(16'h0100, pl_basic, 8'h6A, 1'b0);
        expect_done("after_rst");
        check("after_rst_wr_count", 32'(wr_count - w0), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
